// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] src_a;
   logic [WIDTH-1:0] src_b;
   logic             cancel;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, op, src_a, src_b, cancel,
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, src_a, src_b, cancel,
      output busy, done, hi, lo
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with HI/LO registers.
// Multiply is shift-add and divide is restoring division, one bit per cycle
// on operand magnitudes. A final FIX cycle applies the result signs and
// writes HI/LO together.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam logic [2:0] OP_MTHI = 3'd4;
   localparam logic [2:0] OP_MTLO = 3'd5;

   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] cnt;
   logic             done_r;
   logic [WIDTH-1:0] hi_r, lo_r;

   logic             load, step, fix_wr, wr_hi, wr_lo;

   // Datapath: acc is the running upper product / partial remainder,
   // sh is the multiplier being consumed / quotient being built,
   // md is the multiplicand / divisor magnitude.
   logic [WIDTH-1:0] acc, sh, md, a_raw;
   logic             is_div, neg_q, neg_r, div0;

   logic [WIDTH-1:0] acc_nxt, sh_nxt;
   logic [WIDTH:0]   mul_sum, div_sh;
   logic [WIDTH-1:0] div_dif;
   logic             div_ge;
   logic [WIDTH-1:0] res_hi, res_lo;
   logic             op_signed;

   // Magnitude of an operand; the most-negative value maps to 2**(WIDTH-1).
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      logic signed [WIDTH-1:0] s;
      s = $signed(v);
      return (sgn && s < 0) ? $unsigned(-s) : v;
   endfunction

   // Two's-complement negation of a WIDTH-bit magnitude when neg is set.
   function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] m, input logic neg);
      logic signed [WIDTH-1:0] s;
      s = $signed(m);
      return neg ? $unsigned(-s) : m;
   endfunction

   // Two's-complement negation of a full 2*WIDTH-bit product when neg is set.
   function automatic logic [2*WIDTH-1:0] sign_fix2(input logic [2*WIDTH-1:0] m, input logic neg);
      logic signed [2*WIDTH-1:0] s;
      s = $signed(m);
      return neg ? $unsigned(-s) : m;
   endfunction

   assign op_signed = ~bus.op[0];

   // State, iteration counter and done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         cnt    <= '0;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= fix_wr;
         if (load)
            cnt <= '0;
         else if (step)
            cnt <= cnt + 1'b1;
      end
   end

   // Next-state and control strobes; cancel beats start and aborts any in-flight op.
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      fix_wr    = 1'b0;
      wr_hi     = 1'b0;
      wr_lo     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start && !bus.cancel) begin
               if (!bus.op[2]) begin
                  load      = 1'b1;
                  state_nxt = CALC;
               end else if (bus.op == OP_MTHI) begin
                  wr_hi = 1'b1;
               end else if (bus.op == OP_MTLO) begin
                  wr_lo = 1'b1;
               end
            end
         end
         CALC: begin
            if (bus.cancel) begin
               state_nxt = IDLE;
            end else begin
               step = 1'b1;
               if (cnt == CNT_W'(WIDTH - 1))
                  state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
            fix_wr    = !bus.cancel;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // One multiply or divide iteration on the magnitudes.
   always_comb begin
      mul_sum = {1'b0, acc} + (sh[0] ? {1'b0, md} : {(WIDTH+1){1'b0}});
      div_sh  = {acc, sh[WIDTH-1]};
      div_ge  = div_sh >= {1'b0, md};
      div_dif = div_sh[WIDTH-1:0] - md;
      if (is_div) begin
         acc_nxt = div_ge ? div_dif : div_sh[WIDTH-1:0];
         sh_nxt  = {sh[WIDTH-2:0], div_ge};
      end else begin
         acc_nxt = mul_sum[WIDTH:1];
         sh_nxt  = {mul_sum[0], sh[WIDTH-1:1]};
      end
   end

   // Final HI/LO values with sign correction and the divide-by-zero override.
   always_comb begin
      res_hi = '0;
      res_lo = '0;
      if (!is_div) begin
         {res_hi, res_lo} = sign_fix2({acc, sh}, neg_q);
      end else if (div0) begin
         res_hi = a_raw;
         res_lo = '1;
      end else begin
         res_hi = sign_fix(acc, neg_r);
         res_lo = sign_fix(sh, neg_q);
      end
   end

   // Operand capture on accept, then one iteration per CALC cycle.
   always_ff @(posedge clk) begin
      if (load) begin
         is_div <= bus.op[1];
         neg_q  <= op_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
         neg_r  <= op_signed & bus.src_a[WIDTH-1];
         div0   <= (bus.src_b == '0);
         a_raw  <= bus.src_a;
         acc    <= '0;
         if (bus.op[1]) begin
            sh <= mag(bus.src_a, op_signed);
            md <= mag(bus.src_b, op_signed);
         end else begin
            sh <= mag(bus.src_b, op_signed);
            md <= mag(bus.src_a, op_signed);
         end
      end else if (step) begin
         acc <= acc_nxt;
         sh  <= sh_nxt;
      end
   end

   // HI/LO architectural registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_r <= '0;
         lo_r <= '0;
      end else if (fix_wr) begin
         hi_r <= res_hi;
         lo_r <= res_lo;
      end else begin
         if (wr_hi)
            hi_r <= bus.src_a;
         if (wr_lo)
            lo_r <= bus.src_a;
      end
   end

   assign bus.busy = (state != IDLE);
   assign bus.done = done_r;
   assign bus.hi   = hi_r;
   assign bus.lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hand-written multi-cycle
// sequences, and random operations against a plain-arithmetic reference.
module tb_muldiv_unit;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   muldiv_unit_if #(.WIDTH(32)) bus32 ();
   muldiv_unit_if #(.WIDTH(8))  bus8 ();

   muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
   muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(bus8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Reference result from the MIPS arithmetic rules.
   function automatic void ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
      logic signed [63:0] sp;
      logic [63:0]        up;
      int                 sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      h  = '0;
      l  = '0;
      case (op)
         3'd0: begin sp = 64'(sa) * 64'(sb); {h, l} = sp; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; {h, l} = up; end
         default: begin
            if (b == 0) begin
               l = 32'hFFFFFFFF;
               h = a;
            end else if (op == 3'd2) begin
               if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                  l = 32'h80000000;
                  h = 0;
               end else begin
                  l = sa / sb;
                  h = sa % sb;
               end
            end else begin
               l = a / b;
               h = a % b;
            end
         end
      endcase
   endfunction

   // Count busy cycles and done pulses from the first cycle after accept until busy drops.
   task automatic wait_done32(output int bcyc, output int dcnt);
      bcyc = 0;
      dcnt = 0;
      while (bus32.busy && bcyc < 100) begin
         bcyc++;
         if (bus32.done) dcnt++;
         @(negedge clk);
      end
      if (bus32.done) dcnt++;
   endtask

   task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] h, output logic [31:0] l, output int bcyc, output int dcnt);
      bus32.start = 1'b1;
      bus32.op    = op;
      bus32.src_a = a;
      bus32.src_b = b;
      @(negedge clk);
      bus32.start = 1'b0;
      wait_done32(bcyc, dcnt);
      h = bus32.hi;
      l = bus32.lo;
      @(negedge clk);
      if (bus32.done) dcnt++;
   endtask

   task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] h, output logic [7:0] l, output int bcyc, output int dcnt);
      bus8.start = 1'b1;
      bus8.op    = op;
      bus8.src_a = a;
      bus8.src_b = b;
      @(negedge clk);
      bus8.start = 1'b0;
      bcyc = 0;
      dcnt = 0;
      while (bus8.busy && bcyc < 100) begin
         bcyc++;
         if (bus8.done) dcnt++;
         @(negedge clk);
      end
      if (bus8.done) dcnt++;
      h = bus8.hi;
      l = bus8.lo;
      @(negedge clk);
      if (bus8.done) dcnt++;
   endtask

   initial begin
      vec_t        vecs[12];
      logic [31:0] h, l, eh, el;
      logic [7:0]  h8, l8;
      int          bc, dc;

      vecs[0]  = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
      vecs[1]  = '{3'd0, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[2]  = '{3'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3]  = '{3'd3, 32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF};
      vecs[4]  = '{3'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5]  = '{3'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[6]  = '{3'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[7]  = '{3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[8]  = '{3'd2, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF};
      vecs[9]  = '{3'd2, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF};
      vecs[10] = '{3'd3, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[11] = '{3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

      n_checks = 0;
      n_fail   = 0;
      reset = 1'b1;
      bus32.start = 1'b0; bus32.op = 3'd0; bus32.src_a = '0; bus32.src_b = '0; bus32.cancel = 1'b0;
      bus8.start  = 1'b0; bus8.op  = 3'd0; bus8.src_a  = '0; bus8.src_b  = '0; bus8.cancel  = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      check("reset_hi", 64'(bus32.hi), 64'd0);
      check("reset_lo", 64'(bus32.lo), 64'd0);
      check("reset_busy", 64'(bus32.busy), 64'd0);
      check("reset_done", 64'(bus32.done), 64'd0);

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         run32(vecs[i].op, vecs[i].a, vecs[i].b, h, l, bc, dc);
         check($sformatf("vec%0d_hi", i), 64'(h), 64'(vecs[i].exp_hi));
         check($sformatf("vec%0d_lo", i), 64'(l), 64'(vecs[i].exp_lo));
         check($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'd33);
         check($sformatf("vec%0d_done_pulses", i), 64'(dc), 64'd1);
      end

      // MTHI / MTLO write on the accept edge, no busy, no done
      bus32.start = 1'b1; bus32.op = 3'd4; bus32.src_a = 32'h12345678;
      @(negedge clk);
      bus32.op = 3'd5; bus32.src_a = 32'h9ABCDEF0;
      check("mthi_hi", 64'(bus32.hi), 64'h12345678);
      check("mthi_busy", 64'(bus32.busy), 64'd0);
      check("mthi_done", 64'(bus32.done), 64'd0);
      @(negedge clk);
      bus32.start = 1'b0;
      check("mtlo_lo", 64'(bus32.lo), 64'h9ABCDEF0);
      check("mtlo_hi_kept", 64'(bus32.hi), 64'h12345678);
      check("mtlo_busy", 64'(bus32.busy), 64'd0);
      check("mtlo_done", 64'(bus32.done), 64'd0);

      // Reserved op is ignored
      bus32.start = 1'b1; bus32.op = 3'd6; bus32.src_a = 32'hDEADBEEF;
      @(negedge clk);
      bus32.start = 1'b0;
      check("op6_busy", 64'(bus32.busy), 64'd0);
      check("op6_hi", 64'(bus32.hi), 64'h12345678);

      // Cancel in the middle of a DIV
      bus32.start = 1'b1; bus32.op = 3'd2; bus32.src_a = 32'd1000; bus32.src_b = 32'd3;
      @(negedge clk);
      bus32.start = 1'b0;
      repeat (9) @(negedge clk);
      check("cancel_busy_before", 64'(bus32.busy), 64'd1);
      bus32.cancel = 1'b1;
      @(negedge clk);
      bus32.cancel = 1'b0;
      check("cancel_busy", 64'(bus32.busy), 64'd0);
      check("cancel_hi", 64'(bus32.hi), 64'h12345678);
      check("cancel_lo", 64'(bus32.lo), 64'h9ABCDEF0);
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus32.done || bus32.busy) dc++;
         @(negedge clk);
      end
      check("cancel_no_done", 64'(dc), 64'd0);
      check("cancel_hi_later", 64'(bus32.hi), 64'h12345678);

      // Start held high with a different op: only the first executes
      bus32.start = 1'b1; bus32.op = 3'd1; bus32.src_a = 32'd3; bus32.src_b = 32'd5;
      @(negedge clk);
      bus32.op = 3'd0; bus32.src_a = 32'd7; bus32.src_b = 32'd7;
      repeat (4) @(negedge clk);
      bus32.start = 1'b0;
      bc = 0;
      while (!bus32.done && bc < 100) begin
         bc++;
         @(negedge clk);
      end
      check("held_done_seen", 64'(bus32.done), 64'd1);
      check("held_lo", 64'(bus32.lo), 64'd15);
      check("held_hi", 64'(bus32.hi), 64'd0);
      // Back-to-back start on the done cycle
      bus32.start = 1'b1; bus32.op = 3'd1; bus32.src_a = 32'd6; bus32.src_b = 32'd7;
      @(negedge clk);
      bus32.start = 1'b0;
      check("b2b_accepted", 64'(bus32.busy), 64'd1);
      wait_done32(bc, dc);
      check("b2b_busy_cycles", 64'(bc), 64'd33);
      check("b2b_done", 64'(dc), 64'd1);
      check("b2b_lo", 64'(bus32.lo), 64'd42);

      // Random operations against the reference
      for (int i = 0; i < 150; i++) begin
         logic [2:0]  op;
         logic [31:0] a, b;
         op = 3'($urandom_range(0, 3));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'd0;
            1: begin a = a >> $urandom_range(0, 31); b = b >> $urandom_range(0, 31); end
            2: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
            default: ;
         endcase
         ref_model(op, a, b, eh, el);
         run32(op, a, b, h, l, bc, dc);
         check($sformatf("rnd%0d_op%0d_hi", i, op), 64'(h), 64'(eh));
         check($sformatf("rnd%0d_op%0d_lo", i, op), 64'(l), 64'(el));
         check($sformatf("rnd%0d_done", i), 64'(dc), 64'd1);
      end

      // Reset in the middle of a DIV
      bus32.start = 1'b1; bus32.op = 3'd2; bus32.src_a = 32'd12345; bus32.src_b = 32'd11;
      @(negedge clk);
      bus32.start = 1'b0;
      repeat (19) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_hi", 64'(bus32.hi), 64'd0);
      check("midrst_lo", 64'(bus32.lo), 64'd0);
      check("midrst_busy", 64'(bus32.busy), 64'd0);
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus32.done || bus32.busy) dc++;
         @(negedge clk);
      end
      check("midrst_no_done", 64'(dc), 64'd0);

      // WIDTH=8 instance
      run8(3'd3, 8'd200, 8'd7, h8, l8, bc, dc);
      check("w8_divu_lo", 64'(l8), 64'd28);
      check("w8_divu_hi", 64'(h8), 64'd4);
      check("w8_divu_busy_cycles", 64'(bc), 64'd9);
      check("w8_divu_done", 64'(dc), 64'd1);
      run8(3'd0, 8'hFD, 8'd7, h8, l8, bc, dc);
      check("w8_mult_hi", 64'(h8), 64'hFF);
      check("w8_mult_lo", 64'(l8), 64'hEB);
      run8(3'd2, 8'h80, 8'hFF, h8, l8, bc, dc);
      check("w8_div_ovf_lo", 64'(l8), 64'h80);
      check("w8_div_ovf_hi", 64'(h8), 64'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit with HI/LO result registers, parametrised in operand width. Serves as the multi-cycle EX-side companion to the 5-stage pipeline, executing MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO. The hazard logic holds the pipeline while `busy` is high. It computes one bit per cycle using shift-add for multiply and restoring division for divide. A separate sign-fix cycle handles signed operations.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits.
CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
start  input  1  request; sampled only in IDLE
op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO, 6/7 reserved
src_a  input  WIDTH  rs operand (multiplicand/dividend/MTHI/MTLO data)
src_b  input  WIDTH  rt operand (multiplier/divisor)
cancel  input  1  abort in-flight op (pipeline flush)
busy  output  1  op in flight; pipeline must stall HI/LO readers
done  output  1  one-cycle pulse after HI/LO written by mul/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (synchronous, active-high, highest priority):
  - state=IDLE; hi=0, lo=0, busy=0, done=0; counter=0.
  - Reset mid-operation discards the operation.
- States: IDLE, CALC, FIX.
- IDLE, start=1:
  - op 4/5: write hi/lo from src_a on that edge. No busy, no done. Remains IDLE.
  - op 0-3: latch operands on that edge (E0). Signed ops latch absolute values plus result-sign flags. State goes to CALC, counter=0, busy=1.
  - op 6/7: ignored.
- CALC:
  - One iteration per edge; exactly WIDTH edges (E1..E_WIDTH), then goes to FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction.
  - Write hi/lo atomically.
  - busy goes to 0, done=1 for exactly one cycle, state goes to IDLE.
- Latency: result visible in hi/lo WIDTH+1 cycles after the start-accept edge. busy is high for WIDTH+1 cycles.
- Back-to-back: start asserted while done=1 is accepted, since the state is IDLE.
- start while busy=1: ignored. No queuing, no effect on the running op.
- Multiply result: {hi,lo} = full 2*WIDTH-bit product.
  - MULT: two's-complement signed.
  - MULTU: unsigned.
- Divide result: lo=quotient, hi=remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (src_b=0): lo = all ones, hi = src_a (unmodified dividend). Normal latency, done pulses.
- Signed overflow (DIV of most-negative by -1): lo = most-negative value, hi = 0.
- cancel=1 while busy:
  - Next edge: state=IDLE, busy=0, no done.
  - hi/lo keep their pre-op values.
- cancel in IDLE: no effect. cancel has priority over start in the same cycle.
- hi/lo change only on reset, MTHI/MTLO, or the FIX edge.

Test Plan:
- Reset, then MULTU with src_a=0xFFFFFFFF, src_b=0x2 (WIDTH=32) -> busy high 33 cycles; hi=0x00000001, lo=0xFFFFFFFE; done pulses one cycle.
- MULT with src_a=0xFFFFFFFD (-3), src_b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB (-21).
- DIV with src_a=-7 (0xFFFFFFF9), src_b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU 0x80000000/0 -> lo=0xFFFFFFFF, hi=0x80000000.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 -> hi/lo updated next edge with busy=0 and done=0. Then start a DIV and assert cancel at cycle 10 -> busy low next cycle, hi/lo still 0x12345678/0x9ABCDEF0, no done.
- Start MULTU 3*5 and hold start high for 5 cycles with a different op -> only the first op executes (lo=15). Issue a new start on the done cycle -> accepted; its result arrives 33 cycles later.
- Assert reset at cycle 20 of a DIV -> hi=lo=0, busy=0, done never pulses. Repeat with WIDTH=8: DIVU 200/7 -> lo=28, hi=4, busy for 9 cycles.
